// File: rtl/ysyx_22051013_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller:
// PC width, the bubble PC value and the drain state machine encoding.
package ysyx_22051013_pipe_ctrl_pkg;

  localparam int PC_W = 64;

  // PC value carried by a bubble; also the idle value of redirect_pc.
  localparam logic [PC_W-1:0] BUBBLE_PC = '0;

  // RUN: normal operation. DRAIN: a wrong-path fetch is still in flight
  // in the I-cache and must be discarded when it lands in IF/ID.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/ysyx_22051013_pipe_ctrl_if.sv
// Hazard events from the pipeline stages and the stall/flush/redirect
// controls sent back to the pipeline registers and the PC.
interface ysyx_22051013_pipe_ctrl_if;
  import ysyx_22051013_pipe_ctrl_pkg::*;

  logic            if_busy;
  logic            mem_busy;
  logic            ex_busy;
  logic            id_load_use;
  logic            ex_mispredict;
  logic [PC_W-1:0] ex_target_pc;
  logic            wb_trap;
  logic [PC_W-1:0] trap_pc;

  logic            pc_stall;
  logic            ifid_stall;
  logic            idex_stall;
  logic            exmem_stall;
  logic            memwb_stall;
  logic            ifid_flush;
  logic            idex_flush;
  logic            exmem_flush;
  logic            memwb_flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  // Pipeline side: raises events, obeys the controls.
  modport master (
    output if_busy, mem_busy, ex_busy, id_load_use, ex_mispredict,
           ex_target_pc, wb_trap, trap_pc,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           redirect_valid, redirect_pc
  );

  // Controller side: consumes events, drives the controls.
  modport slave (
    input  if_busy, mem_busy, ex_busy, id_load_use, ex_mispredict,
           ex_target_pc, wb_trap, trap_pc,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// Central hazard and redirect controller for the 5-stage pipeline.
// A fixed-priority encoder turns stage events into per-register stall and
// flush controls plus a PC redirect; a two-state FSM keeps flushing IF/ID
// while a wrong-path fetch drains; two counters track stalls and redirects.
module ysyx_22051013_pipe_ctrl
  import ysyx_22051013_pipe_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22051013_pipe_ctrl_if.slave     bus,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
);

  pipe_state_e state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic            pc_stall;
  logic            ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic            ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  // Priority encoder: trap > D-cache busy > mispredict > EX busy > load-use,
  // then the DRAIN override discards whatever lands in IF/ID.
  always_comb begin
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    idex_stall     = 1'b0;
    exmem_stall    = 1'b0;
    memwb_stall    = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    memwb_flush    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = BUBBLE_PC;

    if (bus.wb_trap) begin
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      exmem_flush    = 1'b1;
      memwb_flush    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = bus.trap_pc;
    end else if (bus.mem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (bus.ex_mispredict) begin
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = bus.ex_target_pc;
    end else if (bus.ex_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_flush = 1'b1;
    end else if (bus.id_load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end

    if (state_q == ST_DRAIN) begin
      ifid_flush = 1'b1;
      ifid_stall = 1'b0;
    end
  end

  // Drive the interface controls from the encoder results.
  always_comb begin
    bus.pc_stall       = pc_stall;
    bus.ifid_stall     = ifid_stall;
    bus.idex_stall     = idex_stall;
    bus.exmem_stall    = exmem_stall;
    bus.memwb_stall    = memwb_stall;
    bus.ifid_flush     = ifid_flush;
    bus.idex_flush     = idex_flush;
    bus.exmem_flush    = exmem_flush;
    bus.memwb_flush    = memwb_flush;
    bus.redirect_valid = redirect_valid;
    bus.redirect_pc    = redirect_pc;
  end

  // Stay in or enter DRAIN while a fetch is outstanding after a redirect;
  // fall back to RUN on the first cycle the I-cache is idle.
  always_comb begin
    state_d = ST_RUN;
    if (bus.if_busy && (redirect_valid || state_q == ST_DRAIN)) begin
      state_d = ST_DRAIN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next counter values; both wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect_valid) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
// Directed bench for the pipeline hazard/redirect controller.
module tb_ysyx_22051013_pipe_ctrl;
  import ysyx_22051013_pipe_ctrl_pkg::*;

  // Event vector bits: {if_busy, mem_busy, ex_busy, id_load_use, ex_mispredict, wb_trap}
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_IFB  = 6'b100000;
  localparam logic [5:0] E_MEM  = 6'b010000;
  localparam logic [5:0] E_EXB  = 6'b001000;
  localparam logic [5:0] E_LU   = 6'b000100;
  localparam logic [5:0] E_MP   = 6'b000010;
  localparam logic [5:0] E_TRAP = 6'b000001;

  // Control vector bits: {pc_s, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, exmem_f, memwb_f, redirect}
  localparam logic [9:0] C_NONE    = 10'b0;
  localparam logic [9:0] C_PC_S    = 10'b1000000000;
  localparam logic [9:0] C_IFID_S  = 10'b0100000000;
  localparam logic [9:0] C_IDEX_S  = 10'b0010000000;
  localparam logic [9:0] C_EXMEM_S = 10'b0001000000;
  localparam logic [9:0] C_IFID_F  = 10'b0000010000;
  localparam logic [9:0] C_IDEX_F  = 10'b0000001000;
  localparam logic [9:0] C_EXMEM_F = 10'b0000000100;
  localparam logic [9:0] C_MEMWB_F = 10'b0000000010;
  localparam logic [9:0] C_RV      = 10'b0000000001;

  localparam logic [63:0] TGT  = 64'h0000_0000_8000_0040;
  localparam logic [63:0] TGT2 = 64'h0000_0000_8000_0080;
  localparam logic [63:0] TPC  = 64'h0000_0000_8000_0100;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  int          total;
  int          bad;

  ysyx_22051013_pipe_ctrl_if bus ();

  ysyx_22051013_pipe_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ctrlVec();
    return {bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.exmem_stall,
            bus.memwb_stall, bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
            bus.memwb_flush, bus.redirect_valid};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of events at the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic [5:0] ev, input logic [63:0] tgt, input logic [63:0] tpc);
    @(negedge clk);
    {bus.if_busy, bus.mem_busy, bus.ex_busy, bus.id_load_use,
     bus.ex_mispredict, bus.wb_trap} = ev;
    bus.ex_target_pc = tgt;
    bus.trap_pc      = tpc;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    {bus.if_busy, bus.mem_busy, bus.ex_busy, bus.id_load_use,
     bus.ex_mispredict, bus.wb_trap} = E_NONE;
    bus.ex_target_pc = '0;
    bus.trap_pc      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    applyStimulus(E_NONE, '0, '0);
    checkOutput("reset_ctrl", 64'(ctrlVec()), 64'(C_NONE));
    checkOutput("reset_rpc", bus.redirect_pc, 64'h0);
    checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("reset_flush_cnt", 64'(flush_cnt), 64'd0);

    // Load-use for one cycle
    applyStimulus(E_LU, '0, '0);
    checkOutput("lu_ctrl", 64'(ctrlVec()), 64'(C_PC_S | C_IFID_S | C_IDEX_F));
    applyStimulus(E_NONE, '0, '0);
    checkOutput("lu_clear", 64'(ctrlVec()), 64'(C_NONE));
    checkOutput("lu_stall_cnt", 64'(stall_cnt), 64'd1);

    // Mispredict with idle fetch
    applyStimulus(E_MP, TGT, '0);
    checkOutput("mp_ctrl", 64'(ctrlVec()), 64'(C_IFID_F | C_IDEX_F | C_RV));
    checkOutput("mp_rpc", bus.redirect_pc, TGT);
    applyStimulus(E_NONE, '0, '0);
    checkOutput("mp_run", 64'(ctrlVec()), 64'(C_NONE));
    checkOutput("mp_flush_cnt", 64'(flush_cnt), 64'd1);

    // Mispredict during fetch: drain for three cycles
    applyStimulus(E_MP | E_IFB, TGT, '0);
    checkOutput("drain0_ctrl", 64'(ctrlVec()), 64'(C_IFID_F | C_IDEX_F | C_RV));
    applyStimulus(E_IFB, '0, '0);
    checkOutput("drain1_ctrl", 64'(ctrlVec()), 64'(C_IFID_F));
    checkOutput("drain1_rpc", bus.redirect_pc, 64'h0);
    applyStimulus(E_IFB | E_LU, '0, '0);
    checkOutput("drain2_lu_ctrl", 64'(ctrlVec()), 64'(C_PC_S | C_IFID_F | C_IDEX_F));
    applyStimulus(E_NONE, '0, '0);
    checkOutput("drain3_fall_ctrl", 64'(ctrlVec()), 64'(C_IFID_F));
    applyStimulus(E_NONE, '0, '0);
    checkOutput("drain_exit_ctrl", 64'(ctrlVec()), 64'(C_NONE));
    checkOutput("drain_flush_cnt", 64'(flush_cnt), 64'd2);
    checkOutput("drain_stall_cnt", 64'(stall_cnt), 64'd2);

    // D-cache busy masks a mispredict for five cycles
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 1) ? (E_MEM | E_MP | E_LU) : (E_MEM | E_MP), TGT2, '0);
      checkOutput($sformatf("mem%0d_ctrl", i), 64'(ctrlVec()),
                  64'(C_PC_S | C_IFID_S | C_IDEX_S | C_EXMEM_S | C_MEMWB_F));
    end
    applyStimulus(E_MP, TGT2, '0);
    checkOutput("mem_release_ctrl", 64'(ctrlVec()), 64'(C_IFID_F | C_IDEX_F | C_RV));
    checkOutput("mem_release_rpc", bus.redirect_pc, TGT2);
    checkOutput("mem_stall_cnt", 64'(stall_cnt), 64'd7);

    // EX busy for three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(E_EXB, '0, '0);
      checkOutput($sformatf("exb%0d_ctrl", i), 64'(ctrlVec()),
                  64'(C_PC_S | C_IFID_S | C_IDEX_S | C_EXMEM_F));
    end
    applyStimulus(E_NONE, '0, '0);
    checkOutput("exb_stall_cnt", 64'(stall_cnt), 64'd10);
    checkOutput("exb_flush_cnt", 64'(flush_cnt), 64'd3);

    // Trap wins over a simultaneous mispredict
    applyStimulus(E_TRAP | E_MP, TGT, TPC);
    checkOutput("trap_ctrl", 64'(ctrlVec()),
                64'(C_IFID_F | C_IDEX_F | C_EXMEM_F | C_MEMWB_F | C_RV));
    checkOutput("trap_rpc", bus.redirect_pc, TPC);
    applyStimulus(E_NONE, '0, '0);
    checkOutput("trap_flush_cnt", 64'(flush_cnt), 64'd4);

    // Reset while draining
    applyStimulus(E_MP | E_IFB, TGT, '0);
    applyStimulus(E_IFB, '0, '0);
    checkOutput("rst_drain_ctrl", 64'(ctrlVec()), 64'(C_IFID_F));
    rst = 1'b1;
    applyStimulus(E_IFB, '0, '0);
    rst = 1'b0;
    applyStimulus(E_IFB, '0, '0);
    checkOutput("rst_drain_run", 64'(ctrlVec()), 64'(C_NONE));
    checkOutput("rst_drain_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("rst_drain_flush_cnt", 64'(flush_cnt), 64'd0);

    // Stall counter wrap
    applyStimulus(E_NONE, '0, '0);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    checkOutput("wrap_preset", 64'(stall_cnt), 64'hFFFF_FFFF);
    applyStimulus(E_EXB, '0, '0);
    applyStimulus(E_NONE, '0, '0);
    checkOutput("wrap_stall_cnt", 64'(stall_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
